// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: programs one of two counter profiles over Avalon-MM,
// polls completion, then qualifies pll_locked. Optional timeout: `PLL_RECONFIG_TIMEOUT_EN.
module pll_reconfig_ctrl #(
  parameter logic [191:0] PROFILE0     = 192'h0,
  parameter logic [191:0] PROFILE1     = 192'h0,
  parameter int unsigned  LOCK_STABLE  = 1024,
  parameter int unsigned  LOCK_TIMEOUT = 4194304
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        cfg_req,
  input  logic        cfg_sel,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        clk_ready,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  output logic        mgmt_read,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_POLL, S_LOCK_WAIT
`ifdef PLL_RECONFIG_TIMEOUT_EN
    , S_ERROR
`endif
  } state_t;

  localparam logic [15:0] LS = 16'(LOCK_STABLE);

  state_t       state_q, state_d;
  logic [2:0]   step_q, step_d;
  logic         sel_q, sel_d;
  logic         gap_q, gap_d;
  logic [15:0]  lock_cnt_q, lock_cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         ready_q, ready_d;
  logic         wr_acc, rd_acc, lock_hit;
  logic [191:0] prof;
  logic         unused_rd;

  assign unused_rd = ^mgmt_readdata[31:1];

`ifdef PLL_RECONFIG_TIMEOUT_EN
  localparam logic [22:0] TO = 23'(LOCK_TIMEOUT);
  logic [22:0] to_cnt_q, to_cnt_d;
  logic        to_hit;
  assign to_hit = (to_cnt_q == TO);
`else
  logic [22:0] unused_to;
  assign unused_to = 23'(LOCK_TIMEOUT);
`endif

  assign cfg_busy   = busy_q;
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;
  assign clk_ready  = ready_q;
  assign mgmt_write = (state_q == S_WRITE);
  assign mgmt_read  = (state_q == S_POLL) && !gap_q;
  assign wr_acc     = mgmt_write && !mgmt_waitrequest;
  assign rd_acc     = mgmt_read && !mgmt_waitrequest;

  // Address/data are pure functions of state and step, so they hold while stalled.
  always_comb begin
    mgmt_address   = 6'd0;
    mgmt_writedata = 32'd0;
    prof           = sel_q ? PROFILE1 : PROFILE0;
    if (state_q == S_WRITE) begin
      case (step_q)
        3'd0:    begin mgmt_address = 6'd0; mgmt_writedata = 32'd1;          end
        3'd1:    begin mgmt_address = 6'd4; mgmt_writedata = prof[31:0];     end
        3'd2:    begin mgmt_address = 6'd3; mgmt_writedata = prof[63:32];    end
        3'd3:    begin mgmt_address = 6'd5; mgmt_writedata = prof[95:64];    end
        3'd4:    begin mgmt_address = 6'd5; mgmt_writedata = prof[127:96];   end
        3'd5:    begin mgmt_address = 6'd5; mgmt_writedata = prof[159:128];  end
        3'd6:    begin mgmt_address = 6'd7; mgmt_writedata = prof[191:160];  end
        default: begin mgmt_address = 6'd2; mgmt_writedata = 32'd1;          end
      endcase
    end else if (state_q == S_POLL) begin
      mgmt_address = 6'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    sel_d      = sel_q;
    gap_d      = 1'b0;
    lock_cnt_d = lock_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    ready_d    = ready_q;

    // Lock qualifier runs only in IDLE and LOCK_WAIT; saturates at the threshold.
    if (!((state_q == S_IDLE) || (state_q == S_LOCK_WAIT)) || !pll_locked)
      lock_cnt_d = 16'd0;
    else if (lock_cnt_q != LS)
      lock_cnt_d = lock_cnt_q + 16'd1;
    lock_hit = (lock_cnt_d == LS);

    case (state_q)
      S_IDLE: begin
        ready_d = lock_hit;
        // done_q high marks the first IDLE cycle after completion; requests there are dropped.
        if (cfg_req && !done_q) begin
          state_d    = S_WRITE;
          step_d     = 3'd0;
          sel_d      = cfg_sel;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
          err_d      = 1'b0;
          lock_cnt_d = 16'd0;
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          if (step_q == 3'd7) state_d = S_POLL;
          else                step_d  = step_q + 3'd1;
        end
      end
      S_POLL: begin
        if (rd_acc) begin
          if (mgmt_readdata[0]) begin
            state_d = S_LOCK_WAIT;
          end else begin
            gap_d = 1'b1;
`ifdef PLL_RECONFIG_TIMEOUT_EN
            if (to_hit) state_d = S_ERROR;
`endif
          end
`ifdef PLL_RECONFIG_TIMEOUT_EN
        end else if (to_hit && !mgmt_read) begin
          state_d = S_ERROR;
`endif
        end
      end
      S_LOCK_WAIT: begin
        if (lock_hit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
`ifdef PLL_RECONFIG_TIMEOUT_EN
        end else if (to_hit) begin
          state_d = S_ERROR;
`endif
        end
      end
`ifdef PLL_RECONFIG_TIMEOUT_EN
      S_ERROR: begin
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef PLL_RECONFIG_TIMEOUT_EN
    if ((state_d == S_ERROR) && (state_q != S_ERROR)) begin
      done_d  = 1'b1;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      ready_d = 1'b0;
    end
    if ((state_d != state_q) || !((state_q == S_POLL) || (state_q == S_LOCK_WAIT)))
      to_cnt_d = 23'd0;
    else if (!to_hit)
      to_cnt_d = to_cnt_q + 23'd1;
    else
      to_cnt_d = to_cnt_q;
`endif
  end

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      step_q     <= 3'd0;
      sel_q      <= 1'b0;
      gap_q      <= 1'b0;
      lock_cnt_q <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      sel_q      <= sel_d;
      gap_q      <= gap_d;
      lock_cnt_q <= lock_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

`ifdef PLL_RECONFIG_TIMEOUT_EN
  always_ff @(posedge clk_74a) begin
    if (!reset_n) to_cnt_q <= 23'd0;
    else          to_cnt_q <= to_cnt_d;
  end
`endif

endmodule
